// File: rtl/psum_drain_serializer.sv
// Drain for the systolic array: snapshots all N final psums on capture and streams
// them out one per handshake, requantized (arithmetic shift, clamp at 0, saturate).
module psum_drain_serializer #(
  parameter int ARRAY_SIZE = 8,
  parameter int P_WIDTH    = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int IDX_W      = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   capture,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*P_WIDTH-1:0] psum_in,
  input  logic [4:0]                             shift_amt,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_WIDTH-1:0]                   out_data,
  output logic [IDX_W-1:0]                       out_index,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   capture_drop
);

  localparam int unsigned N = ARRAY_SIZE * ARRAY_SIZE;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state, state_nx;
  logic [P_WIDTH-1:0]        shadow [N];
  logic [4:0]                shift;
  logic [IDX_W-1:0]          idx;
  logic                      hs, last_hs, load, drop_nx;
  logic signed [P_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]      quant;

  always_comb begin
    hs      = (state == STREAM) && out_ready;
    last_hs = hs && (idx == IDX_W'(N - 1));
    // A capture is accepted in IDLE or exactly on the final handshake (back-to-back frame).
    load    = capture && ((state == IDLE) || last_hs);
    drop_nx = capture && (state == STREAM) && !last_hs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (capture) state_nx = STREAM;
      STREAM:  if (last_hs && !capture) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) shadow[k] <= '0;
      shift        <= '0;
      idx          <= '0;
      capture_drop <= 1'b0;
    end else begin
      capture_drop <= drop_nx;
      if (load) begin
        for (int unsigned k = 0; k < N; k++) shadow[k] <= psum_in[k*P_WIDTH +: P_WIDTH];
        shift <= shift_amt;
        idx   <= '0;
      end else if (last_hs) begin
        idx <= '0;
      end else if (hs) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    shifted = $signed(shadow[idx]) >>> shift;
    quant   = '0;
    if (shifted[P_WIDTH-1])                  quant = '0;
    else if (|shifted[P_WIDTH-2:OUT_WIDTH])  quant = '1;
    else                                     quant = shifted[OUT_WIDTH-1:0];
  end

  always_comb begin
    out_valid = (state == STREAM);
    busy      = (state == STREAM);
    out_data  = out_valid ? quant : '0;
    out_index = out_valid ? idx : '0;
    out_last  = out_valid && (idx == IDX_W'(N - 1));
  end

endmodule

// File: tb/tb_psum_drain_serializer.sv
// Self-checking bench for psum_drain_serializer: requantization table, directed
// multi-cycle sequences and randomized frames against a floor-division reference.
module tb_psum_drain_serializer;

  localparam int N    = 64;
  localparam int PW   = 32;
  localparam int MAXV = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              capture = 1'b0;
  logic [N*PW-1:0]   psum_in = '0;
  logic [4:0]        shift_amt = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        out_data;
  logic [5:0]        out_index;
  logic              out_last;
  logic              busy;
  logic              capture_drop;

  psum_drain_serializer #(.ARRAY_SIZE(8), .P_WIDTH(32), .OUT_WIDTH(8), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .capture(capture), .psum_in(psum_in), .shift_amt(shift_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .capture_drop(capture_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] psum;
    int          sh;
    longint      exp;
  } qvec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] frame   [N];
  logic [31:0] frame_b [N];
  int          shift_b;
  longint      exp_q   [N];
  bit          pat     [6];
  qvec_t       tbl     [10];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: floor(p / 2^sh), then clamp to [0, 255].
  function automatic longint ref_q(logic [31:0] raw, int sh);
    longint p = longint'($signed(raw));
    longint d = longint'(1) << sh;
    longint q = (p >= 0) ? p / d : -((-p + d - 1) / d);
    if (q < 0) return 0;
    if (q > MAXV) return MAXV;
    return q;
  endfunction

  function automatic logic [31:0] rand_psum();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 300));
      1:       return -32'($urandom_range(1, 5000));
      2:       return 32'($urandom_range(0, 100000));
      default: return $urandom();
    endcase
  endfunction

  function automatic int rand_shift();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
  endfunction

  task automatic scramble();
    for (int k = 0; k < N; k++) psum_in[k*PW +: PW] = $urandom();
    shift_amt = 5'($urandom());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    capture = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic start_frame(input int sh);
    for (int k = 0; k < N; k++) psum_in[k*PW +: PW] = frame[k];
    shift_amt = 5'(sh);
    capture   = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    capture = 1'b0;
    scramble();
    for (int k = 0; k < N; k++) exp_q[k] = ref_q(frame[k], sh);
  endtask

  // mode 0: ready held high, 1: fixed pattern, 2: random.
  task automatic drain(input int mode, input int inject_at, input bit chain,
                       output int cyc, output int nhs);
    int  k = 0;
    bit  r;
    bit  drop_exp = 1'b0;
    bit  chained = 1'b0;
    bit  chain_now;
    int  inj = inject_at;
    cyc = 0;
    nhs = 0;
    while (k < N && cyc < 2000) begin
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("index", out_index, k);
      chk("data", out_data, exp_q[k]);
      chk("last", out_last, (k == N - 1) ? 1 : 0);
      chk("drop", capture_drop, drop_exp);
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[cyc % 6];
        default: r = 1'($urandom_range(0, 1));
      endcase
      drop_exp  = 1'b0;
      chain_now = 1'b0;
      scramble();
      if (inj >= 0 && k == inj) begin
        capture  = 1'b1;
        drop_exp = 1'b1;
        inj      = -1;
      end
      if (chain && !chained && k == N - 1) begin
        r = 1'b1;
        for (int j = 0; j < N; j++) psum_in[j*PW +: PW] = frame_b[j];
        shift_amt = 5'(shift_b);
        capture   = 1'b1;
        chained   = 1'b1;
        chain_now = 1'b1;
      end
      out_ready = r;
      @(negedge clk);
      capture = 1'b0;
      cyc++;
      if (r) begin
        nhs++;
        if (chain_now) begin
          for (int j = 0; j < N; j++) begin
            frame[j] = frame_b[j];
            exp_q[j] = ref_q(frame_b[j], shift_b);
          end
          k = 0;
        end else begin
          k++;
        end
      end
    end
    chk("frame_complete", k, N);
    out_ready = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_drop"}, capture_drop, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, nhs;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl = '{
      '{32'd300,        0,  255},
      '{32'hFFFF_FFFB,  0,  0},
      '{32'd1000,       2,  250},
      '{32'd1023,       2,  255},
      '{32'h7FFF_FFFF,  31, 0},
      '{32'hFFFF_FFFF,  31, 0},
      '{32'd50,         0,  50},
      '{32'd256,        1,  128},
      '{32'd510,        1,  255},
      '{32'hFFFF_FF00,  4,  0}
    };

    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", capture_drop, 0);

    // Requantization table: capture a uniform frame, inspect beat 0, abort by reset.
    foreach (tbl[i]) begin
      for (int k = 0; k < N; k++) frame[k] = tbl[i].psum;
      start_frame(tbl[i].sh);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_data", out_data, tbl[i].exp);
      do_reset();
    end

    // Uniform frame: 64 beats of 50 in exactly 64 cycles.
    for (int k = 0; k < N; k++) frame[k] = 32'd50;
    start_frame(0);
    drain(0, -1, 1'b0, cyc, nhs);
    chk("uniform_cycles", cyc, N);
    check_idle("uniform_end");

    // Backpressure: psum[k]=k, ready pattern 1,0,0,1,0,1...
    for (int k = 0; k < N; k++) frame[k] = 32'(k);
    start_frame(0);
    drain(1, -1, 1'b0, cyc, nhs);
    chk("bp_handshakes", nhs, N);
    check_idle("bp_end");

    // Rejected capture at idx 10.
    for (int k = 0; k < N; k++) frame[k] = 32'(k);
    start_frame(0);
    drain(0, 10, 1'b0, cyc, nhs);
    chk("rej_cycles", cyc, N);
    check_idle("rej_end");

    // Back-to-back frames with capture on the final handshake.
    for (int k = 0; k < N; k++) begin
      frame[k]   = 32'(k);
      frame_b[k] = 32'(200 - k);
    end
    shift_b = 0;
    start_frame(0);
    drain(0, -1, 1'b1, cyc, nhs);
    chk("b2b_cycles", cyc, 2 * N);
    check_idle("b2b_end");

    // Reset mid-frame at idx 30.
    for (int k = 0; k < N; k++) frame[k] = 32'(k);
    start_frame(0);
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_index", out_index, 30);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_index", out_index, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_drop", capture_drop, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) frame[k] = rand_psum();
    start_frame(rand_shift());
    drain(2, -1, 1'b0, cyc, nhs);
    check_idle("mid_new_end");

    // Randomized frames, random backpressure, optional rejected capture and chaining.
    for (int f = 0; f < 8; f++) begin
      bit ch = 1'($urandom_range(0, 1));
      int inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 2)) : -1;
      for (int k = 0; k < N; k++) begin
        frame[k]   = rand_psum();
        frame_b[k] = rand_psum();
      end
      shift_b = rand_shift();
      start_frame(rand_shift());
      drain(2, inj, ch, cyc, nhs);
      chk("rand_handshakes", nhs, ch ? 2 * N : N);
      check_idle("rand_end");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_drain_serializer.md
# psum_drain_serializer

Output-side drain for the 8x8 systolic array: snapshots the 64 parallel final partial sums (`Psum_out_stream`) on a single capture pulse and serializes them, one per handshake, toward the output buffer/memory writer. Each value is requantized on the way out: arithmetic right shift, clamp at zero, saturate to `OUT_WIDTH`. It sits between `SystolicArray` and the result store, releasing the array for the next tile as soon as the snapshot is taken.

## Interface
- `ARRAY_SIZE`, default 8: PE rows/cols; frame length N = ARRAY_SIZE*ARRAY_SIZE (64).
- `P_WIDTH`, default 32: psum width, two's complement.
- `OUT_WIDTH`, default 8: output width, unsigned.
- `IDX_W`, default 6: index width, equal to clog2(N).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `capture`  in  1  pulse requesting a snapshot of `psum_in` and `shift_amt`.
- `psum_in`  in  N*P_WIDTH  flattened psums; element k = row*ARRAY_SIZE+col at bits [k*P_WIDTH +: P_WIDTH]; k=63 is PE[7][7].
- `shift_amt`  in  5  right-shift amount, sampled at capture.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  OUT_WIDTH  requantized psum.
- `out_index`  out  IDX_W  element index k of the current beat.
- `out_last`  out  1  high when `out_index` = N-1 and `out_valid` is high.
- `busy`  out  1  a frame is held or streaming.
- `capture_drop`  out  1  one-cycle pulse when a capture is rejected.

## Operation
- States: IDLE, STREAM.
- IDLE: `out_valid`=0, `busy`=0. A `capture` latches all N psums into shadow registers, latches `shift_amt`, sets idx=0, and moves to STREAM.
- STREAM: `out_valid`=1, `busy`=1. Each cycle with `out_valid && out_ready` is a handshake; a handshake at idx<N-1 increments idx.
- A handshake at idx=N-1 returns the block to IDLE, unless `capture` is high in the same cycle. In that case the new frame is latched, idx=0, and the state stays STREAM (back-to-back frames, no bubble).
- A `capture` in STREAM other than on the final handshake is ignored: shadow, idx and shift are unchanged, and `capture_drop` pulses on the next cycle.
- `out_data`, `out_index` and `out_last` are derived only from registered state (shadow[idx], latched shift). They stay stable while `out_valid && !out_ready`. Changes to `psum_in` or `shift_amt` after capture have no effect.
- Requantization, computed at full precision:
  - s = $signed(shadow[idx]) >>> shift (sign-extending).
  - If s<0, out_data=0.
  - Else if s > 2^OUT_WIDTH-1, out_data = 2^OUT_WIDTH-1.
  - Else out_data = s[OUT_WIDTH-1:0].
  - shift ≥ P_WIDTH-1 yields 0 or -1 before the clamp, giving out_data 0.
- `out_ready` is ignored while `out_valid`=0.

## Timing
- Reset (asynchronous, at any time including mid-frame): state=IDLE, idx=0, shadow=0, shift=0. Outputs: `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `capture_drop`=0. The partial frame is discarded.
- Capture latency: `capture` sampled at edge E gives `out_valid`=1 with index 0 from E through E+1; the first handshake is possible at edge E+1.
- Throughput: 1 beat/cycle. A full frame with `out_ready` held high takes exactly N (64) cycles.
- `busy` rises with `out_valid` and falls after the last handshake.
- `capture_drop` is registered and lasts 1 cycle per rejected capture.

## Test plan
- **Uniform frame:** all psums=50, shift 0, `out_ready`=1, one capture → 64 consecutive beats, out_data=50, out_index 0..63, `out_last` only on 63, `busy` falls after beat 63.
- **Requantization boundaries:**
  - psum 300, shift 0 → 255.
  - 32'hFFFFFFFB (−5) → 0.
  - 1000, shift 2 → 250.
  - 1023, shift 2 → 255.
  - 32'h7FFFFFFF, shift 31 → 0.
  - −1, shift 31 → 0.
- **Backpressure:** psum[k]=k, `out_ready` pattern 1,0,0,1,0,1… → data/index held during stalls, each k emitted exactly once in order, 64 handshakes total.
- **Rejected capture:** capture with new psums while idx=10 → `capture_drop` one cycle, stream continues with the original values 10..63, no restart.
- **Back-to-back frames:** capture asserted on the handshake of index 63 → next cycle `out_valid`=1, index 0 with new-frame data, zero idle cycles, no `capture_drop`.
- **Reset mid-frame:** `rst` pulsed at idx=30 → all outputs 0 immediately. A new capture then streams from index 0 with the new data.
